// File: rtl/perf_monitor.sv
// perf_monitor: 64-bit performance counters over MMIO plus sticky simulation-finish capture
module perf_monitor #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          CNT_W     = 64
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    input  logic        stall_i,
    input  logic        ctrl_tsfr_i,
    input  logic        br_misp_i,
    input  logic [31:0] dbus_waddr_i,
    input  logic [31:0] dbus_wdata_i,
    input  logic        dbus_wvalid_i,
    input  logic [31:0] dbus_raddr_i,
    input  logic        dbus_rvalid_i,
    output logic [31:0] dbus_rdata_o,
    output logic        dbus_rdvalid_o,
    output logic        fini_o,
    output logic [31:0] fini_code_o
);
    localparam int HI_W = CNT_W - 32;
    logic [4:0][CNT_W-1:0] cnt;
    logic [4:0][HI_W-1:0]  shd;
    logic [4:0]            inc;
    logic [31:0]           rd_word;
    logic                  freeze, run, wr_win, ctrl_wr, clr, fin_wr, rd_hit;
    assign run     = !fini_o && !freeze;
    assign inc     = {run && ctrl_tsfr_i && br_misp_i, run && ctrl_tsfr_i, run && ex_valid_i && !stall_i, run, 1'b1};
    assign wr_win  = dbus_wvalid_i && !dbus_waddr_i[31] && dbus_waddr_i[31:8] == BASE_ADDR[31:8];
    assign ctrl_wr = wr_win && dbus_waddr_i[7:0] == 8'h28;
    assign clr     = ctrl_wr && dbus_wdata_i[0];
    assign fin_wr  = dbus_wvalid_i && dbus_waddr_i[31];
    assign rd_hit  = dbus_rvalid_i && dbus_raddr_i[31:8] == BASE_ADDR[31:8];
    // register map decode; hi words come from the shadow so 64-bit reads stay coherent
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 5; k++) begin
            if (dbus_raddr_i[7:0] == 8'(8 * k)) rd_word = cnt[k][31:0];
            if (dbus_raddr_i[7:0] == 8'(8 * k + 4)) rd_word = 32'(shd[k]);
        end
        if (dbus_raddr_i[7:0] == 8'h28) rd_word = {30'b0, freeze, 1'b0};
        if (dbus_raddr_i[7:0] == 8'h2C) rd_word = {30'b0, freeze, fini_o};
    end
    // counters (index 0 is mtime, never cleared) and lo-read shadow capture; clear beats increment
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            shd <= '0;
        end else begin
            for (int k = 0; k < 5; k++) begin
                cnt[k] <= (clr && k != 0) ? '0 : cnt[k] + CNT_W'(inc[k]);
                if (rd_hit && dbus_raddr_i[7:0] == 8'(8 * k)) shd[k] <= cnt[k][CNT_W-1:32];
            end
        end
    end
    // freeze control and first-write-wins finish capture
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            freeze      <= 1'b0;
            fini_o      <= 1'b0;
            fini_code_o <= '0;
        end else begin
            if (ctrl_wr) freeze <= dbus_wdata_i[1];
            if (fin_wr && !fini_o) begin
                fini_o      <= 1'b1;
                fini_code_o <= dbus_wdata_i;
            end
        end
    end
    // one-cycle read response; data holds until the next hit
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            dbus_rdvalid_o <= 1'b0;
            dbus_rdata_o   <= '0;
        end else begin
            dbus_rdvalid_o <= rd_hit;
            if (rd_hit) dbus_rdata_o <= rd_word;
        end
    end
endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: randomized and directed checks of perf_monitor against a cycle-level reference model
module tb_perf_monitor;
    localparam logic [31:0] B = 32'h4000_0000;
    logic        clk_i = 0, rst_n = 0;
    logic        ex_valid_i = 0, stall_i = 0, ctrl_tsfr_i = 0, br_misp_i = 0;
    logic [31:0] dbus_waddr_i = 0, dbus_wdata_i = 0, dbus_raddr_i = 0;
    logic        dbus_wvalid_i = 0, dbus_rvalid_i = 0;
    logic [31:0] dbus_rdata_o, fini_code_o;
    logic        dbus_rdvalid_o, fini_o;
    int          n_cmp = 0, n_err = 0;
    logic [63:0] m_cnt [5];
    logic [31:0] m_shd [5];
    logic        m_freeze, m_fini;
    logic [31:0] m_code, m_rdata;

    perf_monitor dut (
        .clk_i(clk_i), .rst_n(rst_n), .ex_valid_i(ex_valid_i), .stall_i(stall_i),
        .ctrl_tsfr_i(ctrl_tsfr_i), .br_misp_i(br_misp_i), .dbus_waddr_i(dbus_waddr_i),
        .dbus_wdata_i(dbus_wdata_i), .dbus_wvalid_i(dbus_wvalid_i), .dbus_raddr_i(dbus_raddr_i),
        .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_o(dbus_rdata_o), .dbus_rdvalid_o(dbus_rdvalid_o),
        .fini_o(fini_o), .fini_code_o(fini_code_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [7:0] o = a[7:0];
        if (o == 8'h28) return {30'b0, m_freeze, 1'b0};
        if (o == 8'h2C) return {30'b0, m_freeze, m_fini};
        if (o < 8'h28 && o[1:0] == 2'b0) return o[2] ? m_shd[o / 8] : m_cnt[o / 8][31:0];
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_cnt[k] = 0;
            m_shd[k] = 0;
        end
        m_freeze = 0;
        m_fini   = 0;
        m_code   = 0;
        m_rdata  = 0;
    endtask

    task automatic step();
        logic        hit = dbus_rvalid_i && dbus_raddr_i[31:8] == B[31:8];
        logic [31:0] er  = model_read(dbus_raddr_i);
        logic        run = !m_fini && !m_freeze;
        logic [7:0]  o   = dbus_raddr_i[7:0];
        if (hit && o < 8'h28 && o[2:0] == 3'b0) m_shd[o / 8] = m_cnt[o / 8][63:32];
        m_cnt[0]++;
        if (run) begin
            m_cnt[1]++;
            if (ex_valid_i && !stall_i) m_cnt[2]++;
            if (ctrl_tsfr_i) m_cnt[3]++;
            if (ctrl_tsfr_i && br_misp_i) m_cnt[4]++;
        end
        if (dbus_wvalid_i && !dbus_waddr_i[31] && dbus_waddr_i[31:8] == B[31:8] && dbus_waddr_i[7:0] == 8'h28) begin
            if (dbus_wdata_i[0]) for (int k = 1; k < 5; k++) m_cnt[k] = 0;
            m_freeze = dbus_wdata_i[1];
        end
        if (dbus_wvalid_i && dbus_waddr_i[31] && !m_fini) begin
            m_fini = 1;
            m_code = dbus_wdata_i;
        end
        if (hit) m_rdata = er;
        @(posedge clk_i);
        @(negedge clk_i);
        check("rdvalid", dbus_rdvalid_o, hit);
        check("rdata", dbus_rdata_o, m_rdata);
        check("fini", fini_o, m_fini);
        check("fini_code", fini_code_o, m_code);
        dbus_wvalid_i = 0;
        dbus_rvalid_i = 0;
    endtask

    task automatic rd(input logic [31:0] a);
        dbus_raddr_i  = a;
        dbus_rvalid_i = 1;
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        dbus_waddr_i  = a;
        dbus_wdata_i  = d;
        dbus_wvalid_i = 1;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (5) @(negedge clk_i);
        check("rst_rdata", dbus_rdata_o, 0);
        check("rst_rdvalid", dbus_rdvalid_o, 0);
        check("rst_fini", fini_o, 0);
        check("rst_code", fini_code_o, 0);
        rst_n = 1;
        ex_valid_i = 1;
        idle(100);
        ex_valid_i = 0;
        rd(B + 32'h08); check("mcycle100", dbus_rdata_o, 100);
        rd(B + 32'h10); check("minstret100", dbus_rdata_o, 100);
        rd(B + 32'h00); check("mtime102", dbus_rdata_o, 102);
        wr(B + 32'h28, 1);
        ctrl_tsfr_i = 1;
        for (int i = 0; i < 10; i++) begin
            br_misp_i = (i == 2 || i == 5 || i == 7);
            step();
        end
        ctrl_tsfr_i = 0;
        br_misp_i   = 0;
        rd(B + 32'h18); check("br_pred10", dbus_rdata_o, 10);
        rd(B + 32'h20); check("br_misp3", dbus_rdata_o, 3);
        ex_valid_i = 1;
        stall_i    = 1;
        idle(5);
        ex_valid_i = 0;
        stall_i    = 0;
        rd(B + 32'h10); check("stall_minstret", dbus_rdata_o, 0);
        dut.cnt[1] = 64'hFFFF_FFF0;
        m_cnt[1]   = 64'hFFFF_FFF0;
        rd(B + 32'h08); check("pre_lo", dbus_rdata_o, 32'hFFFF_FFF0);
        idle(32);
        rd(B + 32'h0C); check("shadow_hi0", dbus_rdata_o, 0);
        rd(B + 32'h08); check("wrap_lo", dbus_rdata_o, 32'h12);
        rd(B + 32'h0C); check("wrap_hi1", dbus_rdata_o, 1);
        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 99);
            ex_valid_i  = 1'($urandom);
            stall_i     = 1'($urandom);
            ctrl_tsfr_i = 1'($urandom);
            br_misp_i   = 1'($urandom);
            if (r < 40) begin
                dbus_raddr_i  = (r < 4) ? B + 32'h100 : B + 32'($urandom_range(0, 15) * 4) + ((r == 5) ? 32'h1 : 32'h0);
                dbus_rvalid_i = 1;
            end
            if (r >= 88) begin
                dbus_waddr_i  = B + 32'($urandom_range(0, 12) * 4);
                dbus_wdata_i  = $urandom;
                dbus_wvalid_i = 1;
            end
            step();
        end
        ex_valid_i  = 1;
        stall_i     = 0;
        ctrl_tsfr_i = 0;
        br_misp_i   = 0;
        wr(B + 32'h28, 1);
        ex_valid_i = 0;
        rd(B + 32'h10); check("clr_wins", dbus_rdata_o, 0);
        dbus_raddr_i  = B + 32'h28;
        dbus_rvalid_i = 1;
        wr(B + 32'h28, 2); check("ctrl_prewrite", dbus_rdata_o, 0);
        rd(B + 32'h2C); check("status_frz", dbus_rdata_o, 2);
        rd(B + 32'h28); check("ctrl_frz", dbus_rdata_o, 2);
        rd(B + 32'h08);
        ex_valid_i = 1;
        idle(5);
        ex_valid_i = 0;
        rd(B + 32'h08);
        rd(B + 32'h10); check("frz_minstret", dbus_rdata_o, 0);
        wr(B + 32'h28, 0);
        idle(4);
        ex_valid_i  = 1;
        ctrl_tsfr_i = 1;
        wr(32'h8000_0000, 1);
        ex_valid_i  = 0;
        ctrl_tsfr_i = 0;
        check("fini_set", fini_o, 1);
        check("fini_code1", fini_code_o, 1);
        idle(3);
        rd(B + 32'h08);
        ex_valid_i = 1;
        idle(3);
        ex_valid_i = 0;
        rd(B + 32'h08);
        rd(B + 32'h00);
        rd(B + 32'h2C); check("status_fini", dbus_rdata_o, 1);
        wr(32'h8000_0000, 2); check("first_code_wins", fini_code_o, 1);
        rd(B + 32'h18);
        #2 rst_n = 0;
        #1;
        check("arst_rdata", dbus_rdata_o, 0);
        check("arst_rdvalid", dbus_rdvalid_o, 0);
        check("arst_fini", fini_o, 0);
        check("arst_code", fini_code_o, 0);
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_n = 1;
        idle(10);
        rd(B + 32'h08); check("resume_mcycle", dbus_rdata_o, 10);
        rd(B + 32'h2C); check("resume_status", dbus_rdata_o, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
